// File: rtl/rm_pkg.sv
// Shared raymarcher definitions: frame geometry, dispatch FSM states and the
// pixel request bundle, so display timing and dispatch agree on one source.
package rm_pkg;

  localparam int CORDW = 10;
  localparam int H_RES = 640;
  localparam int V_RES = 480;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [CORDW-1:0] x;
    logic [CORDW-1:0] y;
    logic             first;
    logic             last;
  } pixel_req_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y pixel counter; clear has priority over advance.
module raster_counter #(
  parameter int H_RES = rm_pkg::H_RES,
  parameter int V_RES = rm_pkg::V_RES,
  parameter int CORDW = rm_pkg::CORDW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             clear,
  output logic [CORDW-1:0] x,
  output logic [CORDW-1:0] y,
  output logic             is_first,
  output logic             is_last
);

  logic x_end;
  logic y_end;

  assign x_end    = (x == CORDW'(H_RES - 1));
  assign y_end    = (y == CORDW'(V_RES - 1));
  assign is_first = (x == '0) && (y == '0);
  assign is_last  = x_end && y_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ray_dispatch.sv
// Raster-order pixel job dispatcher for the raymarcher with credit-limited
// outstanding requests, frame completion pulse and running frame counter.
module ray_dispatch
  import rm_pkg::*;
#(
  parameter int H_RES        = rm_pkg::H_RES,
  parameter int V_RES        = rm_pkg::V_RES,
  parameter int CORDW        = rm_pkg::CORDW,
  parameter int MAX_INFLIGHT = 4,
  parameter int FRAME_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               continuous,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [CORDW-1:0]   req_x,
  output logic [CORDW-1:0]   req_y,
  output logic               req_first,
  output logic               req_last,
  input  logic               resp_valid,
  output logic               busy,
  output logic               frame_done,
  output logic [FRAME_W-1:0] frame_count,
  output logic               resp_err
);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] inflight;
  logic       accept;
  logic       resp_ok;
  logic       clear;
  logic       is_first;
  logic       is_last;

  // req_valid depends only on registered state, so it cannot retract before accept
  assign req_valid = (state == ISSUE) && (inflight < 4'(MAX_INFLIGHT));
  assign accept    = req_valid && req_ready;
  assign resp_ok   = resp_valid && (inflight != '0);
  assign req_first = (state == ISSUE) && is_first;
  assign req_last  = (state == ISSUE) && is_last;
  assign busy      = (state != IDLE);

  raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .CORDW (CORDW)
  ) u_raster (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (accept),
    .clear    (clear),
    .x        (req_x),
    .y        (req_y),
    .is_first (is_first),
    .is_last  (is_last)
  );

  always_comb begin
    state_nxt  = state;
    clear      = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ISSUE;
          clear     = 1'b1;
        end
      end
      ISSUE: begin
        if (accept && is_last) begin
          state_nxt = DRAIN;
          clear     = 1'b1;
        end
      end
      DRAIN: begin
        if (inflight == '0) begin
          frame_done = 1'b1;
          clear      = 1'b1;
          state_nxt  = continuous ? ISSUE : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      inflight    <= '0;
      frame_count <= '0;
      resp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case ({accept, resp_ok})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (frame_done)
        frame_count <= frame_count + 1'b1;
      if (resp_valid && (inflight == '0))
        resp_err <= 1'b1;
    end
  end

endmodule
